// File: rtl/circ_mtx_vec_mul_m31.sv
// Pipelined circulant matrix-vector multiplier over GF(2^WORD_WIDTH - 1): products, row sums, final reduction.
// Optional macro CIRC_MVMUL_IN_REG_EN adds an input register stage (latency 4 instead of 3).
module circ_mtx_vec_mul_m31 #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] mtx_row [0:STATE_SIZE-1],
  input  logic [WORD_WIDTH-1:0] vec     [0:STATE_SIZE-1],
  output logic [WORD_WIDTH-1:0] result  [0:STATE_SIZE-1]
);

  localparam int W  = WORD_WIDTH;
  localparam int N  = STATE_SIZE;
  localparam int AW = W + $clog2(N);
  localparam logic [W-1:0] P = {W{1'b1}};

  // Two Mersenne folds leave at most p, which is the only non-canonical value left to clear.
  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [W:0]     s1;
    logic [W-1:0]   s2;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    s1   = {1'b0, prod[W-1:0]} + {1'b0, prod[2*W-1:W]};
    s2   = s1[W-1:0] + W'(s1[W]);
    return (s2 == P) ? '0 : s2;
  endfunction

  function automatic logic [W-1:0] mod_fold(input logic [AW-1:0] x);
    logic [AW-1:0] f1;
    logic [W-1:0]  f2;
    f1 = AW'(x[W-1:0]) + AW'(x[AW-1:W]);
    f2 = f1[W-1:0] + W'(f1[AW-1:W]);
    return (f2 == P) ? '0 : f2;
  endfunction

  logic [W-1:0] row_s [0:N-1];
  logic [W-1:0] vec_s [0:N-1];

`ifdef CIRC_MVMUL_IN_REG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        row_s[k] <= '0;
        vec_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        row_s[k] <= mtx_row[k];
        vec_s[k] <= vec[k];
      end
    end
  end
`else
  assign row_s = mtx_row;
  assign vec_s = vec;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [W-1:0]  rot    [0:N-1];
    logic [W-1:0]  prod_q [0:N-1];
    logic [AW-1:0] acc;
    logic [AW-1:0] sum_q;
    logic [W-1:0]  res_q;

    // Row gi of the matrix is the first row rotated right by gi positions.
    for (genvar gj = 0; gj < N; gj++) begin : g_rot
      assign rot[gj] = row_s[(gj - gi + N) % N];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j < N; j++) prod_q[j] <= '0;
      end else begin
        for (int j = 0; j < N; j++) prod_q[j] <= mod_mul(rot[j], vec_s[j]);
      end
    end

    always_comb begin
      acc = '0;
      for (int j = 0; j < N; j++) acc = acc + AW'(prod_q[j]);
    end

    // Wide accumulator cannot overflow, so reduction is deferred to the last stage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sum_q <= '0;
        res_q <= '0;
      end else begin
        sum_q <= acc;
        res_q <= mod_fold(sum_q);
      end
    end

    assign result[gi] = res_q;
  end

endmodule

// File: tb/tb_circ_mtx_vec_mul_m31.sv
// Randomized self-checking bench for circ_mtx_vec_mul_m31 against a plain modular-arithmetic model.
// Expected latency follows CIRC_MVMUL_IN_REG_EN.
`timescale 1ns/1ps
module tb_circ_mtx_vec_mul_m31;

  localparam int W = 31;
  localparam int N = 16;
`ifdef CIRC_MVMUL_IN_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam logic [63:0] P = 64'h0000_0000_7FFF_FFFF;
  localparam int MAXSEQ = 32;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] mtx_row [0:N-1];
  logic [W-1:0] vec     [0:N-1];
  logic [W-1:0] result  [0:N-1];

  logic [W-1:0] stim_row [0:MAXSEQ-1][0:N-1];
  logic [W-1:0] stim_vec [0:MAXSEQ-1][0:N-1];
  logic [W-1:0] cap      [0:MAXSEQ-1][0:N-1];

  int total = 0;
  int bad   = 0;

  circ_mtx_vec_mul_m31 #(.WORD_WIDTH(W), .STATE_SIZE(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .mtx_row(mtx_row),
    .vec    (vec),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: direct sum over the circulant definition, reduced with the % operator.
  function automatic logic [W-1:0] ref_elem(input int s, input int i);
    logic [63:0] acc;
    logic [63:0] c;
    logic [63:0] v;
    acc = 64'd0;
    for (int j = 0; j < N; j++) begin
      c   = {33'd0, stim_row[s][(j - i + N) % N]};
      v   = {33'd0, stim_vec[s][j]};
      acc = (acc + (c * v) % P) % P;
    end
    return acc[W-1:0];
  endfunction

  task automatic drive_set(input int s);
    for (int i = 0; i < N; i++) begin
      mtx_row[i] = stim_row[s][i];
      vec[i]     = stim_vec[s][i];
    end
  endtask

  task automatic drive_noise();
    for (int i = 0; i < N; i++) begin
      mtx_row[i] = W'($urandom);
      vec[i]     = W'($urandom);
    end
  endtask

  task automatic fill_random(input int cnt);
    for (int s = 0; s < cnt; s++) begin
      for (int i = 0; i < N; i++) begin
        stim_row[s][i] = ($urandom_range(0, 15) == 0) ? W'(P) : W'($urandom);
        stim_vec[s][i] = ($urandom_range(0, 15) == 0) ? W'(P) : W'($urandom);
      end
    end
  endtask

  // Drives sets 0..cnt-1 on consecutive cycles and records the output belonging to each.
  task automatic push_and_capture(input int cnt);
    @(negedge clk);
    for (int t = 0; t < cnt + LAT - 1; t++) begin
      if (t < cnt) drive_set(t);
      else         drive_noise();
      @(posedge clk);
      @(negedge clk);
      if (t - LAT + 1 >= 0) begin
        for (int i = 0; i < N; i++) cap[t - LAT + 1][i] = result[i];
      end
    end
  endtask

  task automatic test_reset();
    drive_noise();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (result[i] !== '0) begin
        bad++;
        $display("[TB] FAIL reset_state i=%0d got=%h exp=0", i, result[i]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) begin
      stim_row[0][i] = (i == 0) ? W'(1) : W'(0);
      stim_vec[0][i] = W'(i + 1);
    end
    push_and_capture(1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cap[0][i] !== W'(i + 1)) begin
        bad++;
        $display("[TB] FAIL identity i=%0d got=%h exp=%h", i, cap[0][i], W'(i + 1));
      end
    end
  endtask

  task automatic test_rotation();
    for (int i = 0; i < N; i++) begin
      stim_row[0][i] = (i == 1) ? W'(1) : W'(0);
      stim_vec[0][i] = W'(i + 1);
    end
    push_and_capture(1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cap[0][i] !== W'(((i + 1) % N) + 1)) begin
        bad++;
        $display("[TB] FAIL rotation i=%0d got=%h exp=%h", i, cap[0][i], W'(((i + 1) % N) + 1));
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++) begin
      stim_row[0][i] = W'(P - 1);
      stim_vec[0][i] = W'(P - 1);
      stim_row[1][i] = W'(P);
      stim_vec[1][i] = W'($urandom);
    end
    push_and_capture(2);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cap[0][i] !== W'(N)) begin
        bad++;
        $display("[TB] FAIL wrap_minus_one i=%0d got=%h exp=%h", i, cap[0][i], W'(N));
      end
      total++;
      if (cap[1][i] !== '0) begin
        bad++;
        $display("[TB] FAIL wrap_row_p i=%0d got=%h exp=0", i, cap[1][i]);
      end
    end
  endtask

  task automatic test_full_acc();
    for (int i = 0; i < N; i++) begin
      stim_row[0][i] = W'(32'h4000_0000);
      stim_vec[0][i] = W'(32'h4000_0000);
    end
    push_and_capture(1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cap[0][i] !== ref_elem(0, i)) begin
        bad++;
        $display("[TB] FAIL full_acc i=%0d got=%h exp=%h", i, cap[0][i], ref_elem(0, i));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random(1);
      push_and_capture(1);
      for (int i = 0; i < N; i++) begin
        total++;
        if (cap[0][i] !== ref_elem(0, i)) begin
          bad++;
          $display("[TB] FAIL random r=%0d i=%0d got=%h exp=%h", r, i, cap[0][i], ref_elem(0, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(20);
    push_and_capture(20);
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (cap[s][i] !== ref_elem(s, i)) begin
          bad++;
          $display("[TB] FAIL back_to_back s=%0d i=%0d got=%h exp=%h", s, i, cap[s][i], ref_elem(s, i));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    for (int c = 0; c < LAT + 2; c++) begin
      drive_noise();
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if (result[i] !== '0) begin
        bad++;
        $display("[TB] FAIL reset_async i=%0d got=%h exp=0", i, result[i]);
      end
    end
    for (int e = 0; e < 3; e++) begin
      drive_noise();
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        total++;
        if (result[i] !== '0) begin
          bad++;
          $display("[TB] FAIL reset_hold e=%0d i=%0d got=%h exp=0", e, i, result[i]);
        end
      end
    end
    fill_random(1);
    reset = 1'b1;
    drive_set(0);
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      @(negedge clk);
      drive_noise();
      for (int i = 0; i < N; i++) begin
        total++;
        if (e < LAT) begin
          if (result[i] !== '0) begin
            bad++;
            $display("[TB] FAIL post_reset_zero e=%0d i=%0d got=%h exp=0", e, i, result[i]);
          end
        end else begin
          if (result[i] !== ref_elem(0, i)) begin
            bad++;
            $display("[TB] FAIL post_reset_first i=%0d got=%h exp=%h", i, result[i], ref_elem(0, i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotation();
    test_wrap();
    test_full_acc();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
